apb_master_mc: RTL and testbench

- Parametrised, multi-slave APB4 master.
- Accepts single read/write commands on a valid/ready request port and runs the IDLE–SETUP–ENABLE APB sequence with unlimited wait states.
- Decodes the slave from the upper address bits and returns one response per command.
- Sits between user/bridge logic and the APB slave fabric. Supports back-to-back transfers without an IDLE cycle, plus PSTRB.

---
 rtl/apb_master_mc_if.sv | 52 +++++
 rtl/apb_master_mc.sv | 180 ++++++++++++++++++
 tb/tb_apb_master_mc.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_mc_if.sv
// apb_master_mc_if: request/response port plus APB4 bus signals of the
// multi-slave APB master, bundled so the master and its environment share
// one declaration. The master modport is the DUT view; the slave modport is
// the view of whatever drives requests and models the APB slave fabric.
interface apb_master_mc_if #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 2
);
    localparam int STRB_W = DATA_W / 8;

    // Request port
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [STRB_W-1:0]     req_strb;

    // Response port
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB4 bus
    logic [NUM_SLAVES-1:0] psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [STRB_W-1:0]     pstrb;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_W-1:0]     prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_master_mc.sv
// apb_master_mc: parametrised multi-slave APB4 master.
// Takes single read/write commands on a valid/ready port, runs the
// IDLE-SETUP-ENABLE sequence with unlimited wait states, decodes the slave
// from the top address bits and returns one registered response per command.
// A new command may be accepted in the completing ENABLE cycle, giving
// back-to-back transfers with no IDLE cycle in between.
// Optional feature: define APB_MC_TIMEOUT_EN to abort an ENABLE phase after
// TIMEOUT_CYCLES wait cycles with a timeout error response.
module apb_master_mc #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int NUM_SLAVES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            pclk,
    input  logic            presetn,
    apb_master_mc_if.master bus
);
    localparam int SEL_W  = (NUM_SLAVES > 2) ? $clog2(NUM_SLAVES) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [SEL_W:0] NSLV = (SEL_W + 1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ENABLE = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    state_t                state_q;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_W-1:0]     paddr_q;
    logic [DATA_W-1:0]     pwdata_q;
    logic [STRB_W-1:0]     pstrb_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_W-1:0]     rsp_rdata_q;

    // Decoded view of the command currently offered on the request port
    logic [SEL_W-1:0]      idx_d;
    logic                  dec_err_d;
    logic [NUM_SLAVES-1:0] psel_d;
    logic                  pwrite_d;
    logic [ADDR_W-1:0]     paddr_d;
    logic [DATA_W-1:0]     pwdata_d;
    logic [STRB_W-1:0]     pstrb_d;
    logic                  accept_d;

`ifdef APB_MC_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] wcnt_q;
    logic            rsp_to_q;

    assign bus.rsp_timeout = rsp_to_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    // Slave decode and bus values to load on acceptance; a decode error or a
    // read loads zeros so the bus shows nothing undefined in ERR or on reads.
    always_comb begin
        idx_d = '0;
        if (NUM_SLAVES > 1) begin
            idx_d = bus.req_addr[ADDR_W-1 -: SEL_W];
        end
        dec_err_d = ({1'b0, idx_d} >= NSLV);
        psel_d    = dec_err_d ? '0 : (NUM_SLAVES'(1) << idx_d);
        pwrite_d  = bus.req_write & ~dec_err_d;
        paddr_d   = dec_err_d ? '0 : bus.req_addr;
        pwdata_d  = pwrite_d ? bus.req_wdata : '0;
        pstrb_d   = pwrite_d ? bus.req_strb : '0;
    end

    // A command is taken only when the master is idle or finishing a transfer
    assign bus.req_ready = (state_q == ST_IDLE) | ((state_q == ST_ENABLE) & bus.pready);
    assign accept_d      = bus.req_valid & bus.req_ready;

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Transfer FSM with registered bus outputs and registered response pulse
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MC_TIMEOUT_EN
            wcnt_q      <= '0;
            rsp_to_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MC_TIMEOUT_EN
            rsp_to_q    <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ENABLE;
`ifdef APB_MC_TIMEOUT_EN
                    wcnt_q    <= '0;
`endif
                end
                ST_ENABLE: begin
                    if (bus.pready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.pslverr;
                        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                        state_q     <= ST_IDLE;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        paddr_q     <= '0;
                        pwdata_q    <= '0;
                        pstrb_q     <= '0;
                    end
`ifdef APB_MC_TIMEOUT_EN
                    else if (wcnt_q == TO_LAST) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_to_q    <= 1'b1;
                        state_q     <= ST_IDLE;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        paddr_q     <= '0;
                        pwdata_q    <= '0;
                        pstrb_q     <= '0;
                    end else begin
                        wcnt_q <= wcnt_q + TO_W'(1);
                    end
`endif
                end
                ST_ERR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Acceptance (from IDLE or a completing ENABLE) overrides the
            // return to IDLE and loads the next transfer.
            if (accept_d) begin
                state_q   <= dec_err_d ? ST_ERR : ST_SETUP;
                psel_q    <= psel_d;
                penable_q <= 1'b0;
                pwrite_q  <= pwrite_d;
                paddr_q   <= paddr_d;
                pwdata_q  <= pwdata_d;
                pstrb_q   <= pstrb_d;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_mc.sv
// tb_apb_master_mc: randomized bench for apb_master_mc (3 slaves, 16-bit
// data). A transaction-level timeline model predicts, for every accepted
// command, the cycles in which its select/enable phases occur and the cycle
// of its response, and every cycle all DUT outputs are compared against it.
module tb_apb_master_mc;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NS = 3;
    localparam int TO = 4;
    localparam int NCYC = 1600;

    logic pclk = 1'b0;
    logic presetn = 1'b0;

    always #5 pclk = ~pclk;

    apb_master_mc_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS)) bus ();

    apb_master_mc #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk),
        .presetn(presetn),
        .bus(bus)
    );

    int unsigned vecs = 0;
    int unsigned miss = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            miss++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Everything quiet, master ready to accept
    task automatic check_quiet(input string tag);
        check({tag, ".psel"},      32'(bus.psel), 32'd0);
        check({tag, ".penable"},   32'(bus.penable), 32'd0);
        check({tag, ".pwrite"},    32'(bus.pwrite), 32'd0);
        check({tag, ".paddr"},     32'(bus.paddr), 32'd0);
        check({tag, ".pwdata"},    32'(bus.pwdata), 32'd0);
        check({tag, ".pstrb"},     32'(bus.pstrb), 32'd0);
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".rsp_err"},   32'(bus.rsp_err), 32'd0);
        check({tag, ".rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
        check({tag, ".rsp_to"},    32'(bus.rsp_timeout), 32'd0);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic rand_fields();
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
        bus.req_strb  = 2'($urandom_range(0, 3));
    endtask

    typedef struct {
        int             at;
        logic           err;
        logic           to;
        logic [DW-1:0]  rdata;
    } rsp_t;

    rsp_t rq[$];

    // Current bus transaction: select during [cur_start, cur_end)
    bit            cur_act = 0;
    int            cur_start = 0;
    int            cur_end = 0;
    bit            cur_to = 0;
    logic          cur_w = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [1:0]    cur_strb = '0;
    logic [DW-1:0] cur_prdata = '0;
    logic          cur_slverr = 1'b0;
    int            cur_idx = 0;
    int            err_c = -100;
    bit            have_cmd = 0;
    bit            rst_done = 0;

    initial begin
        bit   in_bus;
        bit   in_en;
        bit   busy;
        int   idx;
        int   w_wait;
        rsp_t r;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = '0;
        presetn       = 1'b0;
        repeat (3) @(negedge pclk);
        check_quiet("reset");
        presetn = 1'b1;

        for (int n = 0; n < NCYC; n++) begin
            @(posedge pclk);
            @(negedge pclk);
            cyc++;

            in_bus = cur_act && (cyc >= cur_start) && (cyc < cur_end);
            in_en  = in_bus && (cyc > cur_start);

            // Slave side: ready only in the planned completing cycle
            if (in_en && (cyc == cur_end - 1) && !cur_to) begin
                bus.pready  = 1'b1;
                bus.prdata  = cur_prdata;
                bus.pslverr = cur_slverr;
            end else begin
                bus.pready  = in_en ? 1'b0 : 1'($urandom_range(0, 1));
                bus.prdata  = DW'($urandom);
                bus.pslverr = 1'($urandom_range(0, 1));
            end
            #1;

            check("psel",    32'(bus.psel),    in_bus ? (32'(1) << cur_idx) : 32'd0);
            check("penable", 32'(bus.penable), 32'(in_en));
            check("pwrite",  32'(bus.pwrite),  in_bus ? 32'(cur_w) : 32'd0);
            check("paddr",   32'(bus.paddr),   in_bus ? 32'(cur_addr) : 32'd0);
            check("pwdata",  32'(bus.pwdata),  in_bus ? 32'(cur_wdata) : 32'd0);
            check("pstrb",   32'(bus.pstrb),   in_bus ? 32'(cur_strb) : 32'd0);

            busy = (in_bus && (cyc <= cur_end - 2)) || (in_bus && cur_to) || (cyc == err_c);
            check("req_ready", 32'(bus.req_ready), 32'(!busy));

            if (rq.size() > 0 && rq[0].at == cyc) begin
                r = rq.pop_front();
                check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("rsp_err",   32'(bus.rsp_err), 32'(r.err));
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.rdata));
                check("rsp_to",    32'(bus.rsp_timeout), 32'(r.to));
            end else begin
                check("rsp_idle", 32'(bus.rsp_valid), 32'd0);
            end

            // Asynchronous reset in the middle of a waited ENABLE phase
            if (!rst_done && n > 800 && in_en && (cyc < cur_end - 1)) begin
                presetn = 1'b0;
                #1;
                check_quiet("rst_mid");
                bus.req_valid = 1'b1;
                @(posedge pclk);
                @(negedge pclk);
                check_quiet("rst_hold");
                presetn       = 1'b1;
                bus.req_valid = 1'b0;
                cur_act       = 0;
                have_cmd      = 0;
                err_c         = -100;
                rq.delete();
                rst_done      = 1;
                continue;
            end

            // Completion at the coming edge: response visible next cycle
            if (in_bus && (cyc == cur_end - 1)) begin
                r.at    = cyc + 1;
                r.to    = cur_to;
                r.err   = cur_to ? 1'b1 : cur_slverr;
                r.rdata = (cur_to || cur_w) ? '0 : cur_prdata;
                rq.push_back(r);
            end

            // Request side
            if (!have_cmd) begin
                rand_fields();
                if ($urandom_range(0, 9) < 7) have_cmd = 1;
            end else if ($urandom_range(0, 3) == 0) begin
                rand_fields();
            end
            bus.req_valid = have_cmd;

            if (have_cmd && !busy) begin
                have_cmd = 0;
                idx = int'(bus.req_addr[AW-1 -: 2]);
                if (idx >= NS) begin
                    err_c   = cyc + 1;
                    r.at    = cyc + 2;
                    r.err   = 1'b1;
                    r.to    = 1'b0;
                    r.rdata = '0;
                    rq.push_back(r);
                end else begin
                    cur_act    = 1;
                    cur_start  = cyc + 1;
                    cur_idx    = idx;
                    cur_w      = bus.req_write;
                    cur_addr   = bus.req_addr;
                    cur_wdata  = bus.req_write ? bus.req_wdata : '0;
                    cur_strb   = bus.req_write ? bus.req_strb : '0;
                    cur_prdata = DW'($urandom);
                    cur_slverr = ($urandom_range(0, 3) == 0);
                    cur_to     = 0;
`ifdef APB_MC_TIMEOUT_EN
                    w_wait = $urandom_range(0, 5);
                    if (w_wait >= TO) cur_to = 1;
`else
                    w_wait = $urandom_range(0, 3);
`endif
                    cur_end = cur_to ? (cur_start + 1 + TO) : (cur_start + 2 + w_wait);
                end
            end
        end

        if (!rst_done) begin
            check("rst_reached", 32'd0, 32'd1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
